// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port 8-bit BRAM.
// Out-of-range requests are accepted but kept off the BRAM, and they set a sticky error flag.
module bram_arbiter #(
    parameter int MAX_ADDR = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [10:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_rvalid,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic [10:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_rvalid,
    output logic [7:0]  rdata,
    output logic        err_oob,
    output logic        bram_en,
    output logic        bram_we,
    output logic [10:0] bram_addr,
    output logic [7:0]  bram_di,
    output logic        bram_rst,
    output logic        bram_regce,
    input  logic [7:0]  bram_do
);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    gnt_e        last_gnt_q, last_gnt_d;
    logic        rsp_a_q, rsp_a_d;
    logic        rsp_b_q, rsp_b_d;
    logic        rsp_oob_q, rsp_oob_d;
    logic        err_oob_q, err_oob_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  di_q, di_d;

    logic        grant_a, grant_b, accept, in_range, sel_we;
    logic [10:0] sel_addr;
    logic [7:0]  sel_wdata;

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (!RST) begin
            if (a_valid && (!b_valid || last_gnt_q == GNT_B)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
        accept    = grant_a | grant_b;
        sel_we    = grant_a ? a_we    : b_we;
        sel_addr  = grant_a ? a_addr  : b_addr;
        sel_wdata = grant_a ? a_wdata : b_wdata;
        in_range  = (sel_addr <= 11'(MAX_ADDR));

        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        di_d       = di_q;
        err_oob_d  = err_oob_q;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = addr_q;
        bram_di    = di_q;
        rsp_a_d    = grant_a & ~a_we;
        rsp_b_d    = grant_b & ~b_we;
        rsp_oob_d  = accept & ~sel_we & ~in_range;

        // Out-of-range accesses leave address/data lines parked at their last value.
        if (accept) begin
            last_gnt_d = grant_a ? GNT_A : GNT_B;
            if (in_range) begin
                bram_en   = 1'b1;
                bram_we   = sel_we;
                bram_addr = sel_addr;
                bram_di   = sel_wdata;
                addr_d    = sel_addr;
                di_d      = sel_wdata;
            end else begin
                err_oob_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt_q <= GNT_B;
            rsp_a_q    <= 1'b0;
            rsp_b_q    <= 1'b0;
            rsp_oob_q  <= 1'b0;
            err_oob_q  <= 1'b0;
            addr_q     <= '0;
            di_q       <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rsp_a_q    <= rsp_a_d;
            rsp_b_q    <= rsp_b_d;
            rsp_oob_q  <= rsp_oob_d;
            err_oob_q  <= err_oob_d;
            addr_q     <= addr_d;
            di_q       <= di_d;
        end
    end

    // Responses are masked while reset is high so a read in flight never reports.
    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign a_rvalid   = rsp_a_q & ~RST;
    assign b_rvalid   = rsp_b_q & ~RST;
    assign rdata      = rsp_oob_q ? 8'h00 : bram_do;
    assign err_oob    = err_oob_q;
    assign bram_rst   = RST;
    assign bram_regce = 1'b0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: a 1024-deep write-first BRAM model, directed
// scenarios, then random traffic compared against a rule-level reference model.
module tb_bram_arbiter;

    localparam int MAX_ADDR = 1000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        a_valid, a_we, b_valid, b_we;
    logic [10:0] a_addr, b_addr;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ready, b_ready, a_rvalid, b_rvalid;
    logic [7:0]  rdata;
    logic        err_oob, bram_en, bram_we, bram_rst, bram_regce;
    logic [10:0] bram_addr;
    logic [7:0]  bram_di, bram_do;

    logic [7:0]  bramMem [0:1023];
    logic [7:0]  refMem  [0:1023];

    int checks = 0;
    int failures = 0;

    // Reference state: whoever was granted last, sticky error, and results of the last cycle.
    logic lastWasB;
    logic errModel;
    logic gotA, gotB;

    bram_arbiter #(.MAX_ADDR(MAX_ADDR)) dut (
        .CLK(CLK), .RST(RST),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid),
        .rdata(rdata), .err_oob(err_oob),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di),
        .bram_rst(bram_rst), .bram_regce(bram_regce), .bram_do(bram_do)
    );

    always #5 CLK = ~CLK;

    // Physical BRAM is 1024 deep, so out-of-range addresses would alias if they leaked through.
    always @(posedge CLK) begin
        if (bram_rst) begin
            bram_do <= 8'h00;
        end else if (bram_en) begin
            if (bram_we) begin
                bramMem[bram_addr[9:0]] = bram_di;
                bram_do <= bram_di;
            end else begin
                bram_do <= bramMem[bram_addr[9:0]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        lastWasB = 1'b1;
        errModel = 1'b0;
    endtask

    task automatic resetDut();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_b_ready", b_ready, 0);
        @(posedge CLK);
        @(negedge CLK);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        checkOutput("rst_a_rvalid", a_rvalid, 0);
        checkOutput("rst_b_rvalid", b_rvalid, 0);
        checkOutput("rst_err_oob", err_oob, 0);
        checkOutput("rst_bram_en", bram_en, 0);
        checkOutput("rst_bram_we", bram_we, 0);
        checkOutput("rst_bram_addr", bram_addr, 0);
        checkOutput("rst_bram_di", bram_di, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_bram_rst", bram_rst, 1);
        checkOutput("rst_regce", bram_regce, 0);
        RST = 1'b0;
        modelReset();
    endtask

    // One full cycle: drive at the falling edge, check the request side, step the model
    // at the rising edge, then check the response side at the next falling edge.
    task automatic applyStimulus(input logic av, input logic awe, input logic [10:0] aaddr,
                                 input logic [7:0] awd, input logic bv, input logic bwe,
                                 input logic [10:0] baddr, input logic [7:0] bwd);
        logic        expA, expB, acc, inRange, we, rvA, rvB;
        logic [10:0] addr;
        logic [7:0]  wd, expData;
        a_valid = av;  a_we = awe; a_addr = aaddr; a_wdata = awd;
        b_valid = bv;  b_we = bwe; b_addr = baddr; b_wdata = bwd;
        #1;
        expA    = av && (!bv || lastWasB);
        expB    = bv && !expA;
        acc     = expA || expB;
        addr    = expA ? aaddr : baddr;
        we      = expA ? awe : bwe;
        wd      = expA ? awd : bwd;
        inRange = int'(addr) <= MAX_ADDR;
        checkOutput("a_ready", a_ready, expA);
        checkOutput("b_ready", b_ready, expB);
        checkOutput("bram_en", bram_en, acc && inRange);
        if (acc && inRange) begin
            checkOutput("bram_we", bram_we, we);
            checkOutput("bram_addr", bram_addr, addr);
            if (we) checkOutput("bram_di", bram_di, wd);
        end else begin
            checkOutput("bram_we_idle", bram_we, 0);
        end
        @(posedge CLK);
        rvA = 1'b0;
        rvB = 1'b0;
        expData = 8'h00;
        if (acc) begin
            lastWasB = expB;
            if (!inRange) errModel = 1'b1;
            if (we) begin
                if (inRange) refMem[addr[9:0]] = wd;
            end else begin
                rvA = expA;
                rvB = expB;
                expData = inRange ? refMem[addr[9:0]] : 8'h00;
            end
        end
        gotA = expA;
        gotB = expB;
        @(negedge CLK);
        checkOutput("a_rvalid", a_rvalid, rvA);
        checkOutput("b_rvalid", b_rvalid, rvB);
        checkOutput("err_oob", err_oob, errModel);
        if (rvA || rvB) checkOutput("rdata", rdata, expData);
    endtask

    initial begin
        logic [7:0]  saved1023, saved0;
        logic        aPend, bPend, aWe, bWe;
        logic [10:0] aAd, bAd;
        logic [7:0]  aWd, bWd;
        int          sel;

        for (int i = 0; i < 1024; i++) begin
            bramMem[i] = 8'($urandom);
            refMem[i]  = bramMem[i];
        end
        bramMem[3] = 8'h11; refMem[3] = 8'h11;
        bramMem[4] = 8'h22; refMem[4] = 8'h22;
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        gotA = 0; gotB = 0;
        modelReset();
        resetDut();

        // Write then read-back through A.
        applyStimulus(1, 1, 11'd7, 8'h5A, 0, 0, 0, 0);
        applyStimulus(1, 0, 11'd7, 8'h00, 0, 0, 0, 0);

        // Continuous contention from a fresh reset: A wins the first tie.
        resetDut();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 11'd3, 0, 1, 0, 11'd4, 0);
            checkOutput("tie_order_a", gotA, (i % 2) == 0);
        end

        // B streaming reads.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 11'(i), 0);

        // Top of range, then first out-of-range address.
        applyStimulus(1, 0, 11'd1000, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 11'd1001, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset lands on the response cycle of an accepted read.
        a_valid = 1; a_we = 0; a_addr = 11'd5;
        #1;
        checkOutput("midrst_ready", a_ready, 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("midrst_a_rvalid", a_rvalid, 0);
        checkOutput("midrst_a_ready", a_ready, 0);
        @(negedge CLK);
        resetDut();
        applyStimulus(1, 0, 11'd9, 0, 1, 0, 11'd10, 0);
        checkOutput("post_rst_tie_a", gotA, 1);

        // Out-of-range write must not alias onto the top physical word.
        saved1023 = bramMem[1023];
        saved0    = bramMem[0];
        applyStimulus(1, 1, 11'd2047, 8'hFF, 0, 0, 0, 0);
        checkOutput("mem1023_kept", bramMem[1023], saved1023);
        applyStimulus(1, 0, 11'd1023, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 11'd0, 0, 0, 0, 0, 0);
        checkOutput("mem0_kept", bramMem[0], saved0);

        // Random traffic; each side holds its request until granted.
        resetDut();
        aPend = 0; bPend = 0;
        aWe = 0; bWe = 0; aAd = 0; bAd = 0; aWd = 0; bWd = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!aPend && ($urandom % 4) != 0) begin
                aPend = 1;
                aWe = 1'($urandom);
                sel = int'($urandom % 16);
                aAd = (sel == 0) ? 11'($urandom_range(990, 2047)) : 11'($urandom_range(0, 15));
                aWd = 8'($urandom);
            end
            if (!bPend && ($urandom % 4) != 0) begin
                bPend = 1;
                bWe = 1'($urandom);
                sel = int'($urandom % 16);
                bAd = (sel == 0) ? 11'($urandom_range(990, 2047)) : 11'($urandom_range(0, 15));
                bWd = 8'($urandom);
            end
            applyStimulus(aPend, aWe, aAd, aWd, bPend, bWe, bAd, bWd);
            if (gotA) aPend = 0;
            if (gotB) bPend = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester round-robin arbiter that shares one single-port 8-bit BRAM (11-bit address, 1-cycle registered read, write-first) between two neural-network datapath clients, typically a weight/activation loader and a MAC-array reader. Accepts one request per cycle via valid/ready, drives the BRAM control pins, and routes each read result back to its issuer one cycle later. Adds bounds checking against the populated depth and a sticky error flag.

## Interface

- MAX_ADDR, 1000: highest valid word address; requests above it never reach the BRAM.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  11  word address.
- a_wdata  in  8  write data.
- a_rvalid  out  1  read response for A on rdata.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid: same as A, for requester B.
- rdata  out  8  shared read-response data.
- err_oob  out  1  sticky flag: an out-of-range request was accepted.
- bram_en  out  1  to BRAM EN.
- bram_we  out  1  to BRAM WE.
- bram_addr  out  11  to BRAM ADDR.
- bram_di  out  8  to BRAM DI.
- bram_rst  out  1  to BRAM RST; equals RST.
- bram_regce  out  1  tied 0.
- bram_do  in  8  from BRAM DO.

## Operation

- Arbitration is combinational from the valids and one state bit, last_gnt (A/B).
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not in last_gnt.
  - last_gnt updates to the granted side on every accepted request.
  - last_gnt resets to B, so A wins the first tie.
- a_ready = grant_A, b_ready = grant_B. At most one is high per cycle, and neither is high while RST = 1.
- Ready may depend on valid. A requester must hold valid, we, addr and wdata stable until it sees ready.
- Accepted request with addr <= MAX_ADDR:
  - bram_en = 1, bram_we = we, bram_addr = addr, bram_di = wdata, all in the same cycle (combinational pass-through).
- Accepted request with addr > MAX_ADDR:
  - bram_en = 0.
  - err_oob sets on the next edge and holds until RST.
- When no request is accepted: bram_en = 0 and bram_we = 0. bram_addr and bram_di hold the last driven values to limit toggling.
- Read response pipeline, loaded on every edge:
  - rsp_a / rsp_b: registered, set for exactly one cycle after an accepted read from that side.
  - rsp_oob: registered, marks that read as out of range.
- a_rvalid = rsp_a, b_rvalid = rsp_b.
- rdata = rsp_oob ? 8'h00 : bram_do.
- Writes produce no response. rdata is don't-care when both rvalid are low.
- Back-to-back reads from either side are supported at full rate (one per cycle) with no bubbles.

## Timing

- Read latency is 1 cycle. A request accepted at edge N has its rvalid and rdata valid in the cycle after edge N, sampled at edge N+1.
- A write is committed at the acceptance edge. A read of the same address accepted on the following cycle returns the new data.
- Throughput is one access per cycle in total. Under continuous contention each requester gets every other cycle.
- Reset values: a_ready = 0, b_ready = 0, a_rvalid = 0, b_rvalid = 0, err_oob = 0, bram_en = 0, bram_we = 0, bram_addr = 0, bram_di = 0, rdata = 0.
  - rdata is 0 because bram_rst clears BRAM DO.
- Reset mid-operation: a read accepted in the cycle before RST rises produces no rvalid. The response registers clear on the RST edge.
- Boundary address cases:
  - addr = MAX_ADDR is in range.
  - addr = MAX_ADDR+1 through 2047 are out of range.
  - Address never wraps.

## Test plan

- Reset, then A writes 0x5A to addr 7 and reads addr 7 on the next cycle.
  - Expect a_ready high on both cycles, bram_en high on both cycles.
  - Expect a_rvalid = 1 with rdata = 0x5A one cycle after the read; b_rvalid stays 0.
- A and B both hold reads valid continuously, to addrs 3 and 4 (preloaded 0x11 and 0x22), for 6 cycles.
  - Expect grants A,B,A,B,A,B.
  - Expect responses alternating a_rvalid/0x11 and b_rvalid/0x22 with no idle cycle.
- B alone issues 4 back-to-back reads of addrs 0..3.
  - Expect b_ready held at 1 and four consecutive b_rvalid cycles with the matching data.
- A reads addr 1000, then addr 1001.
  - Expect mem[1000] returned on the first read.
  - For addr 1001: bram_en = 0 in its accept cycle, the response is rdata = 0x00 with a_rvalid = 1, and err_oob = 1 from the next cycle until RST.
- A read is accepted and RST is asserted on the next edge.
  - Expect no rvalid, all outputs at reset values, and a tie after reset granted to A.
- A writes 0xFF to addr 2047.
  - Expect a_ready = 1, bram_en = 0, err_oob set, and memory unchanged: a read of addr 2047 & 0x3FF = addr 1023 shows no change, as does a readback of addr 0.
